// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N:1 registered stream multiplexer.
package stream_mux_pkg;

  localparam int unsigned MODE_SEL = 0;
  localparam int unsigned MODE_RR  = 1;

  // Ceiling log2; callers guarantee n >= 2 so the result is at least 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority search: the first requester after ptr (mod N) wins.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!gnt_vld && req[SW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready multiplexer with a one-entry output register; channel chosen
// by explicit select (MODE_SEL) or round-robin arbitration (MODE_RR).
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned N    = 4,
  parameter int unsigned MODE = MODE_SEL,
  parameter int unsigned SW   = clog2(N)
) (
  input  logic           CLK,
  input  logic           resetl,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  logic          gnt_vld_c;
  logic [SW-1:0] gnt_idx_c;
  logic          load_c;
  logic [W-1:0]  in_words [N];

  logic [W-1:0]  data_q,  data_d;
  logic [SW-1:0] chan_q,  chan_d;
  logic          valid_q, valid_d;

  for (genvar i = 0; i < N; i++) begin : g_words
    assign in_words[i] = in_data[i*W +: W];
  end

  if (MODE == MODE_RR) begin : g_rr
    logic [SW-1:0] ptr_q, ptr_d;
    logic          sel_unused;

    assign sel_unused = ^sel;

    rr_arbiter #(.N(N), .SW(SW)) u_arb (
      .req     (in_valid),
      .ptr     (ptr_q),
      .gnt_vld (gnt_vld_c),
      .gnt_idx (gnt_idx_c)
    );

    // Pointer only advances on an actual load, so a stalled grant keeps its turn.
    always_comb begin
      ptr_d = ptr_q;
      if (load_c) ptr_d = gnt_idx_c;
    end

    always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) ptr_q <= SW'(N - 1);
      else         ptr_q <= ptr_d;
    end
  end else begin : g_sel
    // Out-of-range select values simply never win.
    always_comb begin
      gnt_vld_c = 1'b0;
      gnt_idx_c = sel;
      if (32'(sel) < N) gnt_vld_c = in_valid[sel];
    end
  end

  assign load_c = (~valid_q | out_ready) & gnt_vld_c;

  always_comb begin
    in_ready = '0;
    if (load_c) in_ready[gnt_idx_c] = 1'b1;
  end

  // Load replaces a draining word in the same edge; a pure drain keeps data/chan.
  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    if (load_c) begin
      data_d  = in_words[gnt_idx_c];
      chan_d  = gnt_idx_c;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule
